// File: rtl/eco_equiv_sweeper_pkg.sv
// Shared types and default sizes for the ECO equivalence sweeper.
package eco_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int W_DEF      = 4;
    localparam int SETTLE_DEF = 2;
    localparam int CNT_W_DEF  = 9;

endpackage

// File: rtl/eco_equiv_sweeper_if.sv
// Operand/result and status bundle between the sweeper and the bench environment.
interface eco_equiv_sweeper_if #(
    parameter int W     = 4,
    parameter int CNT_W = 9
);
    logic             start;
    logic [W-1:0]     a_out;
    logic [W-1:0]     b_out;
    logic [W-1:0]     y_dut;
    logic [W-1:0]     y_ref;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] mismatch_cnt;
    logic             fail_valid;
    logic [W-1:0]     fail_a;
    logic [W-1:0]     fail_b;
    logic [W-1:0]     fail_xor;

    modport master (
        input  start, y_dut, y_ref,
        output a_out, b_out, busy, done, pass, mismatch_cnt,
               fail_valid, fail_a, fail_b, fail_xor
    );

    modport slave (
        output start, y_dut, y_ref,
        input  a_out, b_out, busy, done, pass, mismatch_cnt,
               fail_valid, fail_a, fail_b, fail_xor
    );
endinterface

// File: rtl/eco_equiv_sweeper.sv
// Walks every {a,b} vector through the reference and post-ECO netlists,
// counting mismatches and latching the first failing vector.
module eco_equiv_sweeper
    import eco_sweep_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int SETTLE = SETTLE_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    eco_equiv_sweeper_if.master   bus
);

    localparam logic [3:0]     SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [2*W-1:0] VEC_LAST    = '1;

    state_e           state_q, state_d;
    logic [2*W-1:0]   vec_q, vec_d;
    logic [3:0]       scnt_q, scnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fv_q, fv_d;
    logic [W-1:0]     fa_q, fa_d;
    logic [W-1:0]     fb_q, fb_d;
    logic [W-1:0]     fx_q, fx_d;
    logic             pass_q, pass_d;
    logic             mismatch;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

    assign mismatch = (bus.y_dut != bus.y_ref);

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: if (bus.start) state_d = ST_SETTLE;
            ST_SETTLE:        if (scnt_q == SETTLE_LAST) state_d = ST_CHECK;
            ST_CHECK:         state_d = (vec_q == VEC_LAST) ? ST_DONE : ST_SETTLE;
            default:          state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
        bus.done = (state_q == ST_DONE);
    end

    always_comb begin
        vec_d  = vec_q;
        scnt_d = scnt_q;
        cnt_d  = cnt_q;
        fv_d   = fv_q;
        fa_d   = fa_q;
        fb_d   = fb_q;
        fx_d   = fx_q;
        pass_d = pass_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    vec_d  = '0;
                    scnt_d = '0;
                    cnt_d  = '0;
                    fv_d   = 1'b0;
                    fa_d   = '0;
                    fb_d   = '0;
                    fx_d   = '0;
                    pass_d = 1'b0;
                end
            end
            ST_SETTLE: begin
                scnt_d = (scnt_q == SETTLE_LAST) ? 4'd0 : scnt_q + 4'd1;
            end
            ST_CHECK: begin
                if (mismatch) begin
                    cnt_d = sat_inc(cnt_q);
                    if (!fv_q) begin
                        fv_d = 1'b1;
                        fa_d = vec_q[2*W-1:W];
                        fb_d = vec_q[W-1:0];
                        fx_d = bus.y_dut ^ bus.y_ref;
                    end
                end
                // Last vector ends the sweep; pass must see this cycle's mismatch too.
                if (vec_q == VEC_LAST) pass_d = (cnt_d == '0);
                else                   vec_d  = vec_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec_q  <= '0;
            scnt_q <= '0;
            cnt_q  <= '0;
            fv_q   <= 1'b0;
            fa_q   <= '0;
            fb_q   <= '0;
            fx_q   <= '0;
            pass_q <= 1'b0;
        end else begin
            vec_q  <= vec_d;
            scnt_q <= scnt_d;
            cnt_q  <= cnt_d;
            fv_q   <= fv_d;
            fa_q   <= fa_d;
            fb_q   <= fb_d;
            fx_q   <= fx_d;
            pass_q <= pass_d;
        end
    end

    assign bus.a_out        = vec_q[2*W-1:W];
    assign bus.b_out        = vec_q[W-1:0];
    assign bus.mismatch_cnt = cnt_q;
    assign bus.fail_valid   = fv_q;
    assign bus.fail_a       = fa_q;
    assign bus.fail_b       = fb_q;
    assign bus.fail_xor     = fx_q;
    assign bus.pass         = pass_q;

endmodule
